// File: rtl/inst_sram_axi_bridge.sv
// rtl/inst_sram_axi_bridge.sv - instruction SRAM-like to AXI4 single-beat read bridge with fetch cancel
// Optional macro IBRIDGE_RESP_REG_EN: registered data_ok/rdata, rresp errors return a break instruction.
module inst_sram_axi_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        cancel,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [2:0]  outstanding
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;

    ar_state_t   ar_state, ar_next;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;
    logic [2:0]  outstanding_q;
    logic [2:0]  discard_cnt;
    logic        rready_q;
    logic        r_take;
    logic        deliver;

    // A beat with nothing owed is a slave protocol error; it is swallowed.
    assign r_take  = rvalid & rready_q & (outstanding_q != 3'd0);
    assign deliver = r_take & (discard_cnt == 3'd0) & ~cancel;

    assign inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr & (ar_state == AR_IDLE)
                             & (outstanding_q < MAX_CNT) & ~cancel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ar_state <= AR_IDLE;
        else       ar_state <= ar_next;
    end

    always_comb begin
        ar_next = ar_state;
        case (ar_state)
            AR_IDLE: if (inst_sram_addr_ok) ar_next = AR_BUSY;
            AR_BUSY: if (arready)           ar_next = AR_IDLE;
            default:                        ar_next = AR_IDLE;
        endcase
    end

    always_comb begin
        arvalid = (ar_state == AR_BUSY);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            araddr_q      <= 32'd0;
            arsize_q      <= 2'd0;
            outstanding_q <= 3'd0;
            discard_cnt   <= 3'd0;
            rready_q      <= 1'b0;
        end else begin
            rready_q <= 1'b1;
            if (inst_sram_addr_ok) begin
                araddr_q <= inst_sram_addr;
                arsize_q <= inst_sram_size;
            end
            case ({inst_sram_addr_ok, r_take})
                2'b10:   outstanding_q <= outstanding_q + 3'd1;
                2'b01:   outstanding_q <= outstanding_q - 3'd1;
                default: outstanding_q <= outstanding_q;
            endcase
            // Everything owed at the cancel edge is stale, including a same-cycle beat.
            if (cancel)
                discard_cnt <= outstanding_q - (r_take ? 3'd1 : 3'd0);
            else if (r_take && discard_cnt != 3'd0)
                discard_cnt <= discard_cnt - 3'd1;
        end
    end

`ifdef IBRIDGE_RESP_REG_EN
    logic        data_ok_q;
    logic [31:0] rdata_q;
    logic        unused_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            data_ok_q <= deliver;
            if (deliver)
                rdata_q <= (rresp != 2'b00) ? 32'h002a0000 : rdata;
        end
    end

    assign inst_sram_data_ok = data_ok_q & ~cancel;
    assign inst_sram_rdata   = rdata_q;
    assign unused_in         = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};
`else
    logic unused_in;

    assign inst_sram_data_ok = deliver;
    assign inst_sram_rdata   = deliver ? rdata : 32'd0;
    assign unused_in         = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast, rresp};
`endif

    assign arid        = AXI_ID;
    assign araddr      = araddr_q;
    assign arlen       = 8'd0;
    assign arsize      = {1'b0, arsize_q};
    assign arburst     = 2'b01;
    assign rready      = rready_q;
    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// tb/tb_inst_sram_axi_bridge.sv - directed scoreboard bench for inst_sram_axi_bridge
module tb_inst_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req, wr, cancel;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        addr_ok, data_ok;
    logic [31:0] sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready, rready;
    logic [31:0] axi_rdata;
    logic        rvalid, s_valid, r_hold;
    logic [2:0]  outstanding;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 1;
    int cyc   = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } beat_t;

    beat_t       sq[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    inst_sram_axi_bridge #(.MAX_OUTSTANDING(2), .AXI_ID(4'd0)) dut (
        .clk(clk), .rstn(rstn),
        .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
        .inst_sram_wstrb(4'hf), .inst_sram_addr(addr), .inst_sram_wdata(32'hdeadbeef),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
        .cancel(cancel),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(4'd0), .rdata(axi_rdata), .rresp(2'b00), .rlast(1'b1), .rvalid(rvalid),
        .rready(rready), .outstanding(outstanding)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h1c000000) ? 32'h02800c00 : (a ^ 32'h5a5a00ff);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // AXI read slave: fixed latency, optional R hold
    assign rvalid = s_valid & ~r_hold;

    always @(posedge clk) begin
        if (!rstn) begin
            sq.delete();
            s_valid   = 1'b0;
            axi_rdata = 32'd0;
        end else begin
            cyc++;
            if (rvalid && rready && sq.size() > 0) void'(sq.pop_front());
            if (arvalid && arready) sq.push_back('{araddr, cyc + lat - 1});
            #1;
            s_valid   = (sq.size() > 0) && (sq[0].due <= cyc);
            axi_rdata = (sq.size() > 0) ? mem(sq[0].addr) : 32'd0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (rstn && data_ok) begin
            if (exp_q.size() == 0) check("unexpected_data_ok", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("rdata_order", sram_rdata, e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] a);
        bit got = 0;
        tick; req = 1'b1; addr = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (addr_ok) begin
                got = 1;
                exp_q.push_back(mem(a));
                break;
            end
            tick;
        end
        check("issue_accept", 32'(got), 32'd1);
        tick; req = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick;
            @(negedge clk);
            if (outstanding == 3'd0 && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("drain", 32'(ok), 32'd1);
    endtask

    initial begin
        int acc[3];
        int n;
        logic [31:0] a;

        rstn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; addr = 32'd0;
        cancel = 1'b0; arready = 1'b1; r_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_arsize", 32'(arsize), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_rdata", sram_rdata, 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        tick; rstn = 1'b1;
        tick;
        @(negedge clk);
        check("rready_after_release", 32'(rready), 32'd1);

        // single read
        lat = 1;
        tick; req = 1'b1; addr = 32'h1c000000;
        @(negedge clk);
        check("t1_addr_ok", 32'(addr_ok), 32'd1);
        check("t1_out0", 32'(outstanding), 32'd0);
        exp_q.push_back(32'h02800c00);
        tick; req = 1'b0;
        @(negedge clk);
        check("t1_arvalid", 32'(arvalid), 32'd1);
        check("t1_araddr", araddr, 32'h1c000000);
        check("t1_arsize", 32'(arsize), 32'd2);
        check("t1_arlen", 32'(arlen), 32'd0);
        check("t1_arburst", 32'(arburst), 32'd1);
        check("t1_arid", 32'(arid), 32'd0);
        check("t1_out1", 32'(outstanding), 32'd1);
        tick;
        @(negedge clk);
        check("t1_data_ok", 32'(data_ok), 32'd1);
        check("t1_rdata", sram_rdata, 32'h02800c00);
        tick;
        @(negedge clk);
        check("t1_out_end", 32'(outstanding), 32'd0);
        check("t1_arvalid_end", 32'(arvalid), 32'd0);

        // back-to-back with latency 3, full at 2
        lat = 3; a = 32'h1c000000; n = 0;
        acc = '{-1, -1, -1};
        for (int c = 0; c < 20 && n < 3; c++) begin
            tick; req = 1'b1; addr = a;
            @(negedge clk);
            if (addr_ok) begin
                acc[n] = c;
                exp_q.push_back(mem(a));
                a += 32'd4;
                n++;
            end
        end
        tick; req = 1'b0;
        check("t2_acc0", 32'(acc[0]), 32'd0);
        check("t2_acc1", 32'(acc[1]), 32'd2);
        check("t2_acc2", 32'(acc[2]), 32'd5);
        wait_drain(40);

        // AR stall
        lat = 1; arready = 1'b0;
        tick; req = 1'b1; addr = 32'h1c000100;
        @(negedge clk);
        check("t3_addr_ok", 32'(addr_ok), 32'd1);
        exp_q.push_back(mem(32'h1c000100));
        tick; addr = 32'h1c000200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_arvalid_hold", 32'(arvalid), 32'd1);
            check("t3_araddr_stable", araddr, 32'h1c000100);
            check("t3_addr_ok_low", 32'(addr_ok), 32'd0);
            tick;
        end
        req = 1'b0; arready = 1'b1;
        wait_drain(20);

        // cancel with two held responses
        r_hold = 1'b1;
        issue(32'h1c000300);
        issue(32'h1c000304);
        tick; cancel = 1'b1; req = 1'b1; addr = 32'h1c000400;
        @(negedge clk);
        check("t4_out2", 32'(outstanding), 32'd2);
        check("t4_addr_ok_cancel", 32'(addr_ok), 32'd0);
        exp_q.delete();
        tick; cancel = 1'b0; req = 1'b0; r_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_no_data_ok", 32'(data_ok), 32'd0);
            if (outstanding == 3'd0) break;
            tick;
        end
        check("t4_out_zero", 32'(outstanding), 32'd0);
        issue(32'h1c000500);
        wait_drain(20);

        // cancel coinciding with an R beat
        r_hold = 1'b1;
        issue(32'h1c000600);
        issue(32'h1c000604);
        tick; cancel = 1'b1; r_hold = 1'b0;
        @(negedge clk);
        check("t5_rvalid_same", 32'(rvalid), 32'd1);
        check("t5_data_ok_same", 32'(data_ok), 32'd0);
        check("t5_out2", 32'(outstanding), 32'd2);
        exp_q.delete();
        tick; cancel = 1'b0;
        @(negedge clk);
        check("t5_rvalid_next", 32'(rvalid), 32'd1);
        check("t5_data_ok_next", 32'(data_ok), 32'd0);
        check("t5_out1", 32'(outstanding), 32'd1);
        tick;
        @(negedge clk);
        check("t5_out0", 32'(outstanding), 32'd0);
        issue(32'h1c000700);
        wait_drain(20);

        // reset mid-flight
        arready = 1'b0;
        issue(32'h1c000800);
        rstn = 1'b0;
        #1;
        check("t6_arvalid", 32'(arvalid), 32'd0);
        check("t6_outstanding", 32'(outstanding), 32'd0);
        check("t6_rready", 32'(rready), 32'd0);
        check("t6_araddr", araddr, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        arready = 1'b1;
        tick; rstn = 1'b1;
        tick;
        issue(32'h1c000900);
        wait_drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_sram_axi_bridge.md
Name: inst_sram_axi_bridge

Overview:
- Responder end of the instruction SRAM-like interface (req/addr_ok/data_ok) driven by the fetch stage.
- Accepts read-only instruction requests and issues them as single-beat AXI4 read transactions.
- Returns responses in order as data_ok/rdata.
- Provides a cancel input so the fetch stage can drop in-flight responses on branch, exception or ertn redirect without draining them itself.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered requests (1..7).
- AXI_ID, 4'd0: fixed ARID value; all transactions use this ID, so responses arrive in order.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- inst_sram_req  in  1  request valid
- inst_sram_wr  in  1  write flag; must be 0; a request with wr=1 is never accepted
- inst_sram_size  in  2  log2 bytes; copied to arsize[1:0]
- inst_sram_wstrb  in  4  ignored
- inst_sram_addr  in  32  physical address
- inst_sram_wdata  in  32  ignored
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  one response returned this cycle
- inst_sram_rdata  out  32  response data, valid with data_ok
- cancel  in  1  discard every response still owed for requests accepted before this cycle
- arid  out  4  = AXI_ID
- araddr  out  32  latched address
- arlen  out  8  = 0
- arsize  out  3  = {1'b0, latched size}
- arburst  out  2  = 2'b01
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  ignored unless macro enabled
- rlast  in  1  ignored (single beat)
- rvalid  in  1  R valid
- rready  out  1  R ready
- outstanding  out  3  current accepted-but-unanswered count, for debug

Behaviour:
- Reset, asynchronous on rstn low:
  - arvalid=0, araddr=0, arsize=0.
  - outstanding=0, discard_cnt=0.
  - data_ok=0, rdata=0.
  - rready=0 while rstn low; rready=1 from the first cycle after release.
- Reset mid-transaction discards all state; the AXI slave is reset with the same rstn.
- addr_ok is combinational: req & !wr & !arvalid & (outstanding < MAX_OUTSTANDING) & !cancel.
- On addr_ok:
  - araddr/arsize are latched.
  - arvalid=1 from the next cycle.
  - arvalid holds, with address stable, until arready is sampled high, then drops the next cycle.
  - One request occupies AR at a time, so back-to-back acceptance happens at most every 2 cycles when arready is constant 1.
- outstanding: +1 on addr_ok, -1 on an R handshake (rvalid & rready); unchanged when both occur in the same cycle.
- R handshake with discard_cnt==0: data_ok=1, rdata=AXI rdata, combinational in the same cycle. Minimum latency from addr_ok to data_ok is 2 cycles.
- R handshake with discard_cnt>0: data_ok=0; discard_cnt decrements.
- cancel: discard_cnt <= outstanding - (R handshake this cycle ? 1 : 0), taken from values before update.
  - The same-cycle R beat is treated as old, so it is discarded and data_ok=0.
  - addr_ok=0 during the cancel cycle.
  - A pending arvalid is not withdrawn; its response counts toward discard_cnt.
- cancel while discard_cnt>0: recomputed by the same rule, since outstanding already includes the un-drained discards.
- Full: outstanding==MAX_OUTSTANDING forces addr_ok=0 until an R handshake occurs; acceptance is possible again the following cycle.
- Empty: rvalid while outstanding==0 is a protocol violation; the beat is ignored and the count saturates at 0.

Optional Feature:
- IBRIDGE_RESP_REG_EN defined:
  - data_ok/rdata are registered, so they appear one cycle after the R handshake (minimum latency 3 cycles).
  - rresp!=0 forces registered rdata to 32'h002a0000 (break instruction) so fetch raises an exception downstream.
  - cancel also clears a registered-but-undelivered response in the cancel cycle.
- Not defined: combinational path as above; rresp ignored.

Test Plan:
- Single read: req addr=0x1c000000 at cycle 0, arready=1, rvalid one cycle after AR handshake with rdata=0x02800c00 -> addr_ok@0, arvalid@1, data_ok@2 with rdata=0x02800c00, outstanding 0->1->0.
- Back-to-back: continuous req, addr 0x1c000000/04/08, arready=1, MAX_OUTSTANDING=2, slave latency 3 -> accepts at cycles 0,2; third held (addr_ok=0) until first R beat; data_ok order matches addresses.
- AR stall: arready=0 for 5 cycles -> araddr stable, arvalid high continuously, addr_ok=0 throughout.
- Cancel: 2 outstanding, cancel pulse, then 2 R beats then 1 new request -> no data_ok for first two, discard_cnt 2->1->0, new request returns data_ok normally.
- Cancel with same-cycle R beat and outstanding=2 -> that beat dropped, discard_cnt=1, next beat dropped, outstanding reaches 0.
- Reset mid-flight: rstn low with arvalid=1, outstanding=1 -> all outputs return to reset values immediately; after release the first new request completes cleanly.
